pong_ball_engine: RTL and testbench



---
 rtl/pong_ball_engine.sv | 191 +++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
// Pong game logic: ball motion, wall and paddle bounces, scoring and serve sequencing,
// updated once per frame, plus a registered per-pixel "inside the ball" flag for the painter.
module pong_ball_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BALL_SIZE   = 8,
    parameter int SPEED_X     = 2,
    parameter int SPEED_Y     = 1,
    parameter int PADDLE_X_L  = 16,
    parameter int PADDLE_X_R  = 616,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int SCORE_MAX   = 9,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clock_25M,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       serve,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_pixel,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       point_scored,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, PLAY, POINT, GAME_OVER} state_t;

    // All position arithmetic is 11 bits wide so sums near the screen edge cannot wrap.
    localparam logic [10:0] CX     = 11'((H_RES - BALL_SIZE) / 2);
    localparam logic [10:0] CY     = 11'((V_RES - BALL_SIZE) / 2);
    localparam logic [10:0] X_MAX  = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] SPX    = 11'(SPEED_X);
    localparam logic [10:0] SPY    = 11'(SPEED_Y);
    localparam logic [10:0] BSZ    = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_H  = 11'(PADDLE_H);
    localparam logic [10:0] L_FACE = 11'(PADDLE_X_L + PADDLE_W);
    localparam logic [10:0] R_FACE = 11'(PADDLE_X_R - BALL_SIZE);
    localparam logic [3:0]  SMAX   = 4'(SCORE_MAX);
    localparam int          FC_W   = $clog2(SERVE_DELAY + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(SERVE_DELAY - 1);

    state_t          state, state_d;
    logic            dx, dy, dx_d, dy_d;
    logic            serve_q, serve_rise;
    logic [FC_W-1:0] frame_cnt, frame_cnt_d;
    logic [9:0]      ball_x_d, ball_y_d;
    logic [3:0]      score_l_d, score_r_d, score_l_inc, score_r_inc;
    logic            point_d, left_pt, right_pt;
    logic            overlap_l, overlap_r, pixel_d;
    logic [10:0]     x11, y11, sx11, sy11, pl11, pr11;

    assign serve_rise  = serve & ~serve_q;
    assign x11         = {1'b0, ball_x};
    assign y11         = {1'b0, ball_y};
    assign sx11        = {1'b0, sx};
    assign sy11        = {1'b0, sy};
    assign pl11        = {1'b0, paddle_l_y};
    assign pr11        = {1'b0, paddle_r_y};
    assign overlap_l   = (y11 + BSZ > pl11) && (y11 < pl11 + PAD_H);
    assign overlap_r   = (y11 + BSZ > pr11) && (y11 < pr11 + PAD_H);
    assign score_l_inc = (score_l == 4'hF) ? 4'hF : score_l + 4'd1;
    assign score_r_inc = (score_r == 4'hF) ? 4'hF : score_r + 4'd1;
    assign pixel_d     = (sx11 >= x11) && (sx11 < x11 + BSZ) &&
                         (sy11 >= y11) && (sy11 < y11 + BSZ);
    assign game_over   = (state == GAME_OVER);

    // NOTE: every variable gets a default at the top so no path can leave it unassigned
    // and infer a latch.
    always_comb begin
        state_d     = state;
        ball_x_d    = ball_x;
        ball_y_d    = ball_y;
        dx_d        = dx;
        dy_d        = dy;
        score_l_d   = score_l;
        score_r_d   = score_r;
        frame_cnt_d = frame_cnt;
        point_d     = 1'b0;
        left_pt     = 1'b0;
        right_pt    = 1'b0;

        case (state)
            IDLE: begin
                ball_x_d = CX[9:0];
                ball_y_d = CY[9:0];
                if (serve_rise) state_d = PLAY;
            end
            PLAY: begin
                if (frame_start) begin
                    if (dy) begin
                        if (y11 + SPY >= Y_MAX) begin
                            ball_y_d = Y_MAX[9:0];
                            dy_d     = 1'b0;
                        end else ball_y_d = 10'(y11 + SPY);
                    end else begin
                        if (y11 <= SPY) begin
                            ball_y_d = '0;
                            dy_d     = 1'b1;
                        end else ball_y_d = 10'(y11 - SPY);
                    end

                    if (dx) begin
                        if (x11 <= R_FACE && x11 + SPX >= R_FACE && overlap_r) begin
                            ball_x_d = R_FACE[9:0];
                            dx_d     = 1'b0;
                        end else if (x11 + SPX >= X_MAX) left_pt = 1'b1;
                        else ball_x_d = 10'(x11 + SPX);
                    end else begin
                        if (x11 >= L_FACE && x11 <= L_FACE + SPX && overlap_l) begin
                            ball_x_d = L_FACE[9:0];
                            dx_d     = 1'b1;
                        end else if (x11 <= SPX) right_pt = 1'b1;
                        else ball_x_d = 10'(x11 - SPX);
                    end

                    // The serve goes toward whoever conceded the point.
                    if (left_pt || right_pt) begin
                        point_d     = 1'b1;
                        ball_x_d    = CX[9:0];
                        ball_y_d    = CY[9:0];
                        dy_d        = 1'b1;
                        dx_d        = left_pt;
                        frame_cnt_d = '0;
                        if (left_pt) score_l_d = score_l_inc;
                        else         score_r_d = score_r_inc;
                        state_d = (left_pt ? score_l_inc : score_r_inc) == SMAX ? GAME_OVER : POINT;
                    end
                end
            end
            POINT: begin
                ball_x_d = CX[9:0];
                ball_y_d = CY[9:0];
                if (frame_start) begin
                    if (frame_cnt == FC_LAST) state_d = PLAY;
                    else frame_cnt_d = frame_cnt + 1'b1;
                end
            end
            GAME_OVER: begin
                ball_x_d = CX[9:0];
                ball_y_d = CY[9:0];
                if (serve_rise) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    dx_d      = 1'b1;
                    dy_d      = 1'b1;
                    state_d   = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clock_25M) begin
        if (reset) begin
            state        <= IDLE;
            ball_x       <= CX[9:0];
            ball_y       <= CY[9:0];
            dx           <= 1'b1;
            dy           <= 1'b1;
            score_l      <= '0;
            score_r      <= '0;
            point_scored <= 1'b0;
            ball_pixel   <= 1'b0;
            serve_q      <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            state        <= state_d;
            ball_x       <= ball_x_d;
            ball_y       <= ball_y_d;
            dx           <= dx_d;
            dy           <= dy_d;
            score_l      <= score_l_d;
            score_r      <= score_r_d;
            point_scored <= point_d;
            ball_pixel   <= pixel_d;
            serve_q      <= serve;
            frame_cnt    <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: stimulus pushes expected outputs tagged with a cycle
// number; a negedge monitor pops and compares them as the DUT presents each cycle's outputs.
module tb_pong_ball_engine;

    typedef enum {F_X, F_Y, F_SL, F_SR, F_PS, F_GO, F_PIX, F_PSCNT} field_t;
    typedef struct {
        int     cyc;
        field_t f;
        int     exp;
        string  name;
    } exp_t;

    logic       clock_25M = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] paddle_l_y = '0;
    logic [9:0] paddle_r_y = '0;
    logic [9:0] sx = '0;
    logic [9:0] sy = '0;
    logic [9:0] ball_x, ball_y;
    logic       ball_pixel, point_scored, game_over;
    logic [3:0] score_l, score_r;

    exp_t q[$];
    int   cyc = 0;
    int   ps_count = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    pong_ball_engine #(.SCORE_MAX(2)) dut (
        .clock_25M   (clock_25M),
        .reset       (reset),
        .frame_start (frame_start),
        .serve       (serve),
        .paddle_l_y  (paddle_l_y),
        .paddle_r_y  (paddle_r_y),
        .sx          (sx),
        .sy          (sy),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .ball_pixel  (ball_pixel),
        .score_l     (score_l),
        .score_r     (score_r),
        .point_scored(point_scored),
        .game_over   (game_over)
    );

    always #20 clock_25M = ~clock_25M;
    always @(posedge clock_25M) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        int act;
        case (e.f)
            F_X:     act = int'(ball_x);
            F_Y:     act = int'(ball_y);
            F_SL:    act = int'(score_l);
            F_SR:    act = int'(score_r);
            F_PS:    act = int'(point_scored);
            F_GO:    act = int'(game_over);
            F_PIX:   act = int'(ball_pixel);
            default: act = ps_count;
        endcase
        n_checks++;
        if (act != e.exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d (cycle %0d)",
                     e.name, e.f.name(), act, e.exp, e.cyc);
        end
    endtask

    // Monitor: counts point pulses, then checks everything due this cycle.
    always @(negedge clock_25M) begin
        if (!reset && point_scored) ps_count++;
        while (q.size() > 0 && q[0].cyc <= cyc) check(q.pop_front());
    end

    task automatic push(input string name, input field_t f, input int exp);
        exp_t e;
        e.cyc  = cyc;
        e.f    = f;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic exp_ball(input string name, input int x, input int y);
        push(name, F_X, x);
        push(name, F_Y, y);
    endtask

    task automatic exp_reset(input string name);
        exp_ball(name, 316, 236);
        push(name, F_SL, 0);
        push(name, F_SR, 0);
        push(name, F_PS, 0);
        push(name, F_GO, 0);
        push(name, F_PIX, 0);
    endtask

    task automatic tick();
        @(posedge clock_25M);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic do_serve();
        serve = 1'b1;
        tick();
        serve = 1'b0;
        tick();
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        tick();
        exp_reset(name);
        reset = 1'b0;
    endtask

    // Pulse the frame on which a point is expected and check the one-cycle pulse.
    task automatic score_frame(input string name, input int sl, input int sr, input int go,
                               input int total);
        frame_start = 1'b1;
        tick();
        push(name, F_PS, 1);
        push(name, F_SL, sl);
        push(name, F_SR, sr);
        push(name, F_GO, go);
        exp_ball(name, 316, 236);
        frame_start = 1'b0;
        tick();
        push({name, "_after"}, F_PS, 0);
        push({name, "_after"}, F_PSCNT, total);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        do_reset("reset");

        frames(5);
        exp_reset("idle_no_motion");

        serve = 1'b1;
        repeat (3) tick();
        serve = 1'b0;
        tick();
        frames(1);
        exp_ball("first_move", 318, 237);
        do_serve();
        frames(1);
        exp_ball("serve_ignored_in_play", 320, 238);

        do_reset("reset_2");
        serve = 1'b1;
        frame_start = 1'b1;
        tick();
        serve = 1'b0;
        frame_start = 1'b0;
        tick();
        exp_ball("serve_with_frame_no_move", 316, 236);
        frames(1);
        exp_ball("serve_with_frame_then_move", 318, 237);

        do_reset("reset_pix");
        sx = 10'd316;
        sy = 10'd236;
        push("pix_latency", F_PIX, 0);
        tick();
        push("pix_corner_tl", F_PIX, 1);
        sx = 10'd324;
        tick();
        push("pix_right_out", F_PIX, 0);
        sx = 10'd315;
        tick();
        push("pix_left_out", F_PIX, 0);
        sx = 10'd323;
        sy = 10'd243;
        tick();
        push("pix_corner_br", F_PIX, 1);
        sx = 10'd316;
        sy = 10'd244;
        tick();
        push("pix_below_out", F_PIX, 0);
        sx = '0;
        sy = '0;

        do_reset("reset_bounce");
        paddle_r_y = 10'd350;
        paddle_l_y = 10'd250;
        do_serve();
        frames(146);
        exp_ball("right_bounce", 608, 382);
        frames(1);
        exp_ball("after_right_bounce", 606, 383);
        frames(291);
        exp_ball("left_bounce", 24, 270);
        frames(1);
        exp_ball("after_left_bounce", 26, 269);

        do_reset("reset_right_pt");
        paddle_r_y = 10'd350;
        paddle_l_y = 10'd0;
        do_serve();
        frames(147);
        exp_ball("rp_approach_r", 606, 383);
        frames(302);
        exp_ball("rp_edge", 2, 259);
        push("rp_edge", F_PS, 0);
        score_frame("right_scores", 0, 1, 0, 1);
        frames(60);
        exp_ball("rp_serve_delay", 316, 236);
        frames(1);
        exp_ball("rp_serve_left", 314, 237);

        reset = 1'b1;
        tick();
        exp_reset("reset_mid_play");
        reset = 1'b0;
        frames(2);
        exp_ball("reset_mid_play_idle", 316, 236);

        do_reset("reset_left_pt");
        paddle_r_y = 10'd0;
        paddle_l_y = 10'd0;
        do_serve();
        frames(157);
        exp_ball("lp_edge", 630, 393);
        score_frame("left_scores", 1, 0, 0, 2);
        frames(59);
        exp_ball("point_59", 316, 236);
        frames(1);
        exp_ball("point_60", 316, 236);
        frames(1);
        exp_ball("point_resume", 318, 237);

        frames(156);
        exp_ball("go_edge", 630, 393);
        score_frame("game_over_point", 2, 0, 1, 3);
        frames(10);
        exp_ball("game_over_static", 316, 236);
        push("game_over_static", F_GO, 1);
        do_serve();
        push("restart", F_SL, 0);
        push("restart", F_SR, 0);
        push("restart", F_GO, 0);
        frames(1);
        exp_ball("restart_move", 318, 237);

        tick();
        tick();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
